// File: rtl/pool_writeback_if.sv
// Bundle between the pooling lanes, the SRAM write port and the status outputs of pool_writeback.
// Lanes push without backpressure. The write port uses valid/ready: a beat is transferred on
// a rising edge where wr_en_o && wr_ready_i, and while wr_en_o is high the beat holds stable until that edge.
interface pool_writeback_if #(
  parameter int POOL_NUM      = 16,
  parameter int ADDRESS_WIDTH = 10,
  parameter int DATA_WIDTH    = 8
);
  localparam int LANE_W = (POOL_NUM > 1) ? $clog2(POOL_NUM) : 1;

  logic [POOL_NUM-1:0]                    pool_last_i;
  logic [POOL_NUM-1:0]                    pool_valid_i;
  logic [POOL_NUM-1:0][DATA_WIDTH-1:0]    pool_result_i;
  logic [POOL_NUM-1:0][ADDRESS_WIDTH-1:0] pool_result_address_i;
  logic                                   wr_ready_i;
  logic                                   wr_en_o;
  logic [LANE_W-1:0]                      wr_lane_o;
  logic [ADDRESS_WIDTH-1:0]               wr_addr_o;
  logic [DATA_WIDTH-1:0]                  wr_data_o;
  logic                                   busy_o;
  logic                                   done_o;
  logic                                   overflow_o;
  logic [1:0]                             state_o;

  modport slave (
    input  pool_last_i, pool_valid_i, pool_result_i, pool_result_address_i, wr_ready_i,
    output wr_en_o, wr_lane_o, wr_addr_o, wr_data_o, busy_o, done_o, overflow_o, state_o
  );

  modport master (
    output pool_last_i, pool_valid_i, pool_result_i, pool_result_address_i, wr_ready_i,
    input  wr_en_o, wr_lane_o, wr_addr_o, wr_data_o, busy_o, done_o, overflow_o, state_o
  );
endinterface

// File: rtl/pool_writeback.sv
// Per-lane FIFOs feeding a single SRAM write port through a round-robin arbiter and one output
// register; a small FSM tracks tile completion via the per-lane last flags.
module pool_writeback #(
  parameter int POOL_NUM      = 16,
  parameter int ADDRESS_WIDTH = 10,
  parameter int DATA_WIDTH    = 8,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  pool_writeback_if.slave       bus
);
  localparam int LANE_W = (POOL_NUM > 1) ? $clog2(POOL_NUM) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int ENT_W  = ADDRESS_WIDTH + DATA_WIDTH;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_DRAIN   = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [ENT_W-1:0]                 mem_q [POOL_NUM][FIFO_DEPTH];
  logic [POOL_NUM-1:0][PTR_W-1:0]   wptr_q, wptr_d;
  logic [POOL_NUM-1:0][PTR_W-1:0]   rptr_q, rptr_d;
  logic [POOL_NUM-1:0][CNT_W-1:0]   cnt_q, cnt_d;
  logic [POOL_NUM-1:0]              last_seen_q, last_seen_d;
  logic [LANE_W-1:0]                rr_ptr_q, rr_ptr_d;
  logic                             out_valid_q, out_valid_d;
  logic [LANE_W-1:0]                out_lane_q, out_lane_d;
  logic [ADDRESS_WIDTH-1:0]         out_addr_q, out_addr_d;
  logic [DATA_WIDTH-1:0]            out_data_q, out_data_d;
  logic                             overflow_q, overflow_d;
  logic [1:0]                       state_q, state_d;

  logic [POOL_NUM-1:0]              push, pop, fifo_empty;
  logic                             drop_any;
  logic                             grant_valid;
  logic [LANE_W-1:0]                grant_lane;
  logic                             out_load;
  logic                             all_last, all_empty;

  // Fullness is judged on the registered count, so a same-cycle pop never rescues a beat.
  always_comb begin
    push       = '0;
    fifo_empty = '0;
    drop_any   = 1'b0;
    for (int l = 0; l < POOL_NUM; l++) begin
      fifo_empty[l] = (cnt_q[l] == '0);
      push[l]       = bus.pool_valid_i[l] && (cnt_q[l] != CNT_W'(FIFO_DEPTH));
      if (bus.pool_valid_i[l] && (cnt_q[l] == CNT_W'(FIFO_DEPTH))) drop_any = 1'b1;
    end
  end

  always_comb begin : arb
    int idx;
    grant_valid = 1'b0;
    grant_lane  = '0;
    idx         = 0;
    for (int i = 0; i < POOL_NUM; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= POOL_NUM) idx = idx - POOL_NUM;
      if (!grant_valid && !fifo_empty[idx]) begin
        grant_valid = 1'b1;
        grant_lane  = LANE_W'(idx);
      end
    end
  end

  assign out_load = grant_valid && (!out_valid_q || bus.wr_ready_i);

  always_comb begin
    pop    = '0;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    for (int l = 0; l < POOL_NUM; l++) begin
      pop[l]    = out_load && (grant_lane == LANE_W'(l));
      wptr_d[l] = wptr_q[l] + PTR_W'(push[l]);
      rptr_d[l] = rptr_q[l] + PTR_W'(pop[l]);
      cnt_d[l]  = cnt_q[l] + CNT_W'(push[l]) - CNT_W'(pop[l]);
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_lane_d  = out_lane_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    rr_ptr_d    = rr_ptr_q;
    if (out_load) begin
      out_valid_d              = 1'b1;
      out_lane_d               = grant_lane;
      {out_addr_d, out_data_d} = mem_q[grant_lane][rptr_q[grant_lane]];
      rr_ptr_d = (grant_lane == LANE_W'(POOL_NUM - 1)) ? '0 : grant_lane + LANE_W'(1);
    end else if (bus.wr_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  assign all_last  = &last_seen_q;
  assign all_empty = (&fifo_empty) && !out_valid_q;

  // A last beat arriving during DONE is kept so it counts toward the next tile.
  always_comb begin
    last_seen_d = ((state_q == S_DONE) ? '0 : last_seen_q)
                | (bus.pool_valid_i & bus.pool_last_i);
    overflow_d  = overflow_q | drop_any;
    state_d     = state_q;
    case (state_q)
      S_IDLE:    if (|bus.pool_valid_i) state_d = S_COLLECT;
      S_COLLECT: if (all_last) state_d = all_empty ? S_DONE : S_DRAIN;
      S_DRAIN:   if (all_empty) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    for (int l = 0; l < POOL_NUM; l++) begin
      if (push[l]) mem_q[l][wptr_q[l]] <= {bus.pool_result_address_i[l], bus.pool_result_i[l]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      last_seen_q <= '0;
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_lane_q  <= '0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      overflow_q  <= 1'b0;
      state_q     <= S_IDLE;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cnt_q       <= cnt_d;
      last_seen_q <= last_seen_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_lane_q  <= out_lane_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      overflow_q  <= overflow_d;
      state_q     <= state_d;
    end
  end

  assign bus.wr_en_o    = out_valid_q;
  assign bus.wr_lane_o  = out_lane_q;
  assign bus.wr_addr_o  = out_addr_q;
  assign bus.wr_data_o  = out_data_q;
  assign bus.busy_o     = (state_q != S_IDLE);
  assign bus.done_o     = (state_q == S_DONE);
  assign bus.overflow_o = overflow_q;
  assign bus.state_o    = state_q;
endmodule

// File: tb/tb_pool_writeback.sv
// Bench for pool_writeback: directed scenarios plus a randomized stream, scored against
// per-lane expected queues of {addr, data}.
module tb_pool_writeback;
  localparam int POOL_NUM = 16;
  localparam int AW       = 10;
  localparam int DW       = 8;
  localparam int DEPTH    = 4;
  localparam int LW       = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pool_writeback_if #(.POOL_NUM(POOL_NUM), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  pool_writeback #(
    .POOL_NUM(POOL_NUM), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [AW+DW-1:0]    lane_q [POOL_NUM][$];
  logic [LW-1:0]       got_lane_q [$];
  int                  n_cmp = 0;
  int                  n_err = 0;
  int                  n_wr  = 0;
  int                  n_done = 0;
  int                  wr_at_done = 0;
  int                  base;
  int                  sent;
  logic                stall_pending = 1'b0;
  logic                prev_done = 1'b0;
  logic [LW+AW+DW-1:0] prev_beat = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.pool_valid_i          = '0;
    bus.pool_last_i           = '0;
    bus.pool_result_i         = '0;
    bus.pool_result_address_i = '0;
  endtask

  task automatic send(input int lane, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                      input logic last, input logic store);
    bus.pool_valid_i[lane]          = 1'b1;
    bus.pool_last_i[lane]           = last;
    bus.pool_result_address_i[lane] = addr;
    bus.pool_result_i[lane]         = data;
    if (store) lane_q[lane].push_back({addr, data});
  endtask

  // Called at a falling edge once inputs for the coming rising edge are set.
  task automatic cycle();
    if (prev_done) check("busy_after_done", 32'(bus.busy_o), 32'd0);
    prev_done = bus.done_o;
    if (bus.done_o) begin
      n_done++;
      wr_at_done = n_wr;
    end
    if (stall_pending) begin
      check("stall_hold_en", 32'(bus.wr_en_o), 32'd1);
      check("stall_hold_beat", 32'({bus.wr_lane_o, bus.wr_addr_o, bus.wr_data_o}), 32'(prev_beat));
    end
    stall_pending = bus.wr_en_o && !bus.wr_ready_i;
    prev_beat     = {bus.wr_lane_o, bus.wr_addr_o, bus.wr_data_o};
    if (bus.wr_en_o && bus.wr_ready_i) begin
      n_wr++;
      got_lane_q.push_back(bus.wr_lane_o);
      check("sb_expected_write", 32'(lane_q[bus.wr_lane_o].size() != 0), 32'd1);
      if (lane_q[bus.wr_lane_o].size() != 0)
        check("sb_beat", 32'({bus.wr_addr_o, bus.wr_data_o}), 32'(lane_q[bus.wr_lane_o].pop_front()));
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("rst_wr_en", 32'(bus.wr_en_o), 32'd0);
    check("rst_wr_lane", 32'(bus.wr_lane_o), 32'd0);
    check("rst_wr_addr", 32'(bus.wr_addr_o), 32'd0);
    check("rst_wr_data", 32'(bus.wr_data_o), 32'd0);
    check("rst_busy", 32'(bus.busy_o), 32'd0);
    check("rst_done", 32'(bus.done_o), 32'd0);
    check("rst_overflow", 32'(bus.overflow_o), 32'd0);
    for (int l = 0; l < POOL_NUM; l++) lane_q[l].delete();
    got_lane_q.delete();
    stall_pending = 1'b0;
    prev_done     = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    bus.wr_ready_i = 1'b0;
    @(negedge clk);

    // Single beat: two-cycle latency, exactly one write.
    do_reset();
    base = n_wr;
    bus.wr_ready_i = 1'b1;
    send(3, 10'h005, 8'h7F, 1'b0, 1'b1);
    cycle();
    check("s1_en_cycle1", 32'(bus.wr_en_o), 32'd0);
    cycle();
    check("s1_en_cycle2", 32'(bus.wr_en_o), 32'd1);
    check("s1_lane", 32'(bus.wr_lane_o), 32'd3);
    check("s1_addr", 32'(bus.wr_addr_o), 32'h005);
    check("s1_data", 32'(bus.wr_data_o), 32'h7F);
    repeat (6) cycle();
    check("s1_write_count", 32'(n_wr - base), 32'd1);

    // All lanes at once: 16 back-to-back writes in lane order.
    do_reset();
    base = n_wr;
    bus.wr_ready_i = 1'b1;
    for (int l = 0; l < POOL_NUM; l++) send(l, AW'($urandom), DW'($urandom), 1'b0, 1'b1);
    cycle();
    cycle();
    for (int i = 0; i < POOL_NUM; i++) begin
      check("s2_consecutive_en", 32'(bus.wr_en_o), 32'd1);
      cycle();
    end
    check("s2_idle_after", 32'(bus.wr_en_o), 32'd0);
    check("s2_write_count", 32'(n_wr - base), 32'd16);
    for (int i = 0; i < POOL_NUM; i++)
      check("s2_lane_order", 32'((i < got_lane_q.size()) ? got_lane_q[i] : LW'(0)), 32'(i));

    // Overflow: FIFO plus output register hold 5, the 6th is dropped.
    do_reset();
    base = n_wr;
    bus.wr_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) check("s3_no_overflow_yet", 32'(bus.overflow_o), 32'd0);
      send(0, AW'(i), DW'($urandom), 1'b0, i < 5);
      cycle();
    end
    check("s3_overflow", 32'(bus.overflow_o), 32'd1);
    check("s3_outreg_full", 32'(bus.wr_en_o), 32'd1);
    bus.wr_ready_i = 1'b1;
    repeat (12) cycle();
    check("s3_write_count", 32'(n_wr - base), 32'd5);
    check("s3_overflow_sticky", 32'(bus.overflow_o), 32'd1);

    // Full tile: every lane last, then a single done pulse and idle.
    do_reset();
    base = n_wr;
    n_done = 0;
    bus.wr_ready_i = 1'b1;
    for (int l = 0; l < POOL_NUM; l++) send(l, AW'($urandom), DW'($urandom), 1'b1, 1'b1);
    cycle();
    check("s4_busy", 32'(bus.busy_o), 32'd1);
    for (int i = 0; i < 60 && n_done == 0; i++) cycle();
    check("s4_done_seen", 32'(n_done), 32'd1);
    check("s4_writes_before_done", 32'(wr_at_done - base), 32'd16);
    cycle();
    check("s4_done_one_cycle", 32'(bus.done_o), 32'd0);
    check("s4_idle", 32'(bus.busy_o), 32'd0);
    repeat (4) cycle();
    check("s4_done_count", 32'(n_done), 32'd1);

    // Backpressure: ready toggles every cycle during and after the stream.
    do_reset();
    base = n_wr;
    for (int i = 0; i < 40; i++) begin
      bus.wr_ready_i = (i % 2 == 0);
      if (i < 8) send(i % 3, AW'($urandom), DW'($urandom), 1'b0, 1'b1);
      cycle();
    end
    check("s5_write_count", 32'(n_wr - base), 32'd8);
    for (int l = 0; l < 3; l++) check("s5_lane_drained", 32'(lane_q[l].size()), 32'd0);

    // Reset with three beats buffered: nothing is written afterwards.
    do_reset();
    base = n_wr;
    bus.wr_ready_i = 1'b0;
    send(1, AW'($urandom), DW'($urandom), 1'b0, 1'b1);
    send(2, AW'($urandom), DW'($urandom), 1'b0, 1'b1);
    send(5, AW'($urandom), DW'($urandom), 1'b0, 1'b1);
    cycle();
    cycle();
    check("s6_buffered", 32'(bus.wr_en_o), 32'd1);
    do_reset();
    bus.wr_ready_i = 1'b1;
    repeat (10) cycle();
    check("s6_no_writes", 32'(n_wr - base), 32'd0);

    // Randomized stream; lanes never offered more than the buffering they can hold.
    do_reset();
    base = n_wr;
    sent = 0;
    for (int c = 0; c < 400; c++) begin
      bus.wr_ready_i = ($urandom_range(0, 3) != 0);
      for (int l = 0; l < POOL_NUM; l++) begin
        if (lane_q[l].size() < DEPTH && $urandom_range(0, 15) == 0) begin
          send(l, AW'($urandom), DW'($urandom), ($urandom_range(0, 7) == 0), 1'b1);
          sent++;
        end
      end
      cycle();
    end
    bus.wr_ready_i = 1'b1;
    for (int c = 0; c < 200 && n_wr - base != sent; c++) cycle();
    check("rnd_write_count", 32'(n_wr - base), 32'(sent));
    check("rnd_no_overflow", 32'(bus.overflow_o), 32'd0);
    for (int l = 0; l < POOL_NUM; l++) check("rnd_lane_drained", 32'(lane_q[l].size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
